// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Control FSM for a direct-mapped data cache with 256-bit lines
//               (64 sets, tag = addr[31:11], index = addr[10:5],
//               word = addr[4:2]). Looks up CPU requests in the array, writes
//               store data on hits, writes back dirty victims, refills
//               missing lines from lower memory and replays the lookup.
//               Keeps hit / miss / write-back counters.
// Ports       : clk, rst (sync, active low)
//               cpu_*  : CPU load/store port, cpu_ready one-cycle completion
//               arr_*  : array compare/read/fill controls and lookup results
//               mem_*  : lower-memory request/ack handshake (line transfers)
//               *_count: performance counters (wrap at 2^32)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_be,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_stall,
    output logic         arr_enable,
    output logic         arr_compare,
    output logic         arr_read,
    output logic [31:0]  arr_addr,
    output logic [31:0]  arr_wdata,
    output logic [3:0]   arr_be,
    output logic [255:0] arr_line_wdata,
    input  logic         arr_hit,
    input  logic         arr_valid,
    input  logic         arr_dirty,
    input  logic [31:0]  arr_victim_addr,
    input  logic [31:0]  arr_rdata,
    input  logic [255:0] arr_line_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [255:0] mem_wline,
    input  logic [255:0] mem_rline,
    input  logic         mem_ack,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  wb_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITE     = 3'd2,
        S_WRITEBACK = 3'd3,
        S_REFILL    = 3'd4,
        S_INSTALL   = 3'd5,
        S_RESPOND   = 3'd6
    } state_t;

    state_t r_state;
    logic   r_we;
    logic   r_replay;
    logic   w_hit;

    // A tag match on an invalid line is a miss.
    assign w_hit = arr_hit & arr_valid;

    // All outputs are registered: each transition sets up the outputs
    // belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_replay       <= 1'b0;
            cpu_rdata      <= '0;
            cpu_ready      <= 1'b0;
            cpu_stall      <= 1'b0;
            arr_enable     <= 1'b0;
            arr_compare    <= 1'b0;
            arr_read       <= 1'b0;
            arr_addr       <= '0;
            arr_wdata      <= '0;
            arr_be         <= '0;
            arr_line_wdata <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wline      <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            wb_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        arr_addr    <= cpu_addr;
                        arr_wdata   <= cpu_wdata;
                        arr_be      <= cpu_be;
                        r_we        <= cpu_we;
                        r_replay    <= 1'b0;
                        cpu_stall   <= 1'b1;
                        arr_enable  <= 1'b1;
                        arr_compare <= 1'b1;
                        arr_read    <= 1'b1;
                        r_state     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    // The replay after an install is not a new access.
                    if (!r_replay) begin
                        if (w_hit) begin
                            hit_count <= hit_count + 32'd1;
                        end else begin
                            miss_count <= miss_count + 32'd1;
                        end
                    end
                    arr_enable  <= 1'b0;
                    arr_compare <= 1'b0;
                    arr_read    <= 1'b0;
                    if (w_hit && !r_we) begin
                        cpu_rdata <= arr_rdata;
                        cpu_ready <= 1'b1;
                        r_state   <= S_RESPOND;
                    end else if (w_hit) begin
                        arr_enable  <= 1'b1;
                        arr_compare <= 1'b1;
                        r_state     <= S_WRITE;
                    end else if (arr_valid && arr_dirty) begin
                        mem_wline <= arr_line_rdata;
                        mem_addr  <= arr_victim_addr;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        r_state   <= S_WRITEBACK;
                    end else begin
                        mem_addr <= {arr_addr[31:5], 5'b0};
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        r_state  <= S_REFILL;
                    end
                end

                S_WRITE: begin
                    arr_enable  <= 1'b0;
                    arr_compare <= 1'b0;
                    cpu_rdata   <= '0;
                    cpu_ready   <= 1'b1;
                    r_state     <= S_RESPOND;
                end

                S_WRITEBACK: begin
                    if (mem_ack) begin
                        wb_count <= wb_count + 32'd1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        r_state  <= S_REFILL;
                    end
                end

                S_REFILL: begin
                    // Entered from WRITEBACK with mem_req low: spend one idle
                    // cycle, then issue the refill. An ack seen while the
                    // request is low is ignored.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {arr_addr[31:5], 5'b0};
                    end else if (mem_ack) begin
                        arr_line_wdata <= mem_rline;
                        mem_req        <= 1'b0;
                        arr_enable     <= 1'b1;
                        r_state        <= S_INSTALL;
                    end
                end

                S_INSTALL: begin
                    r_replay    <= 1'b1;
                    arr_compare <= 1'b1;
                    arr_read    <= 1'b1;
                    r_state     <= S_LOOKUP;
                end

                S_RESPOND: begin
                    cpu_ready <= 1'b0;
                    cpu_rdata <= '0;
                    cpu_stall <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed bench for dcache_ctrl with a behavioural cache array,
//               a lower-memory responder and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready, cpu_stall;
    logic         arr_enable, arr_compare, arr_read;
    logic [31:0]  arr_addr, arr_wdata;
    logic [3:0]   arr_be;
    logic [255:0] arr_line_wdata;
    logic         arr_hit, arr_valid, arr_dirty;
    logic [31:0]  arr_victim_addr, arr_rdata;
    logic [255:0] arr_line_rdata;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wline, mem_rline;
    logic         mem_ack;
    logic [31:0]  hit_count, miss_count, wb_count;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .arr_enable(arr_enable), .arr_compare(arr_compare), .arr_read(arr_read),
        .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_be(arr_be),
        .arr_line_wdata(arr_line_wdata),
        .arr_hit(arr_hit), .arr_valid(arr_valid), .arr_dirty(arr_dirty),
        .arr_victim_addr(arr_victim_addr), .arr_rdata(arr_rdata),
        .arr_line_rdata(arr_line_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural cache array ----------------
    bit [20:0]  a_tag   [64];
    bit         a_valid [64];
    bit         a_dirty [64];
    bit [255:0] a_line  [64];
    logic [5:0] t_idx;
    logic [2:0] t_word;

    assign t_idx           = arr_addr[10:5];
    assign t_word          = arr_addr[4:2];
    assign arr_hit         = (a_tag[t_idx] == arr_addr[31:11]);
    assign arr_valid       = a_valid[t_idx];
    assign arr_dirty       = a_dirty[t_idx];
    assign arr_victim_addr = {a_tag[t_idx], t_idx, 5'b0};
    assign arr_line_rdata  = a_line[t_idx];
    assign arr_rdata       = a_line[t_idx][t_word*32 +: 32];

    always @(posedge clk) begin
        if (arr_enable && arr_compare && !arr_read) begin
            for (int b = 0; b < 4; b++)
                if (arr_be[b]) a_line[t_idx][t_word*32 + b*8 +: 8] <= arr_wdata[b*8 +: 8];
            a_dirty[t_idx] <= 1'b1;
        end else if (arr_enable && !arr_compare && !arr_read) begin
            a_line[t_idx]  <= arr_line_wdata;
            a_tag[t_idx]   <= arr_addr[31:11];
            a_valid[t_idx] <= 1'b1;
            a_dirty[t_idx] <= 1'b0;
        end
    end

    // ---------------- lower memory responder ----------------
    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] line;
    } mem_txn_t;

    mem_txn_t     txn_q [$];
    logic [31:0]  exp_q [$];
    logic [255:0] mem_model [logic [31:0]];
    bit           resp_en = 1'b1;
    int           ack_delay = 3;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [255:0] dflt_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i * 4);
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return dflt_line(a);
    endfunction

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt = 0;
                end else if (mem_req) begin
                    cnt++;
                    if (cnt >= ack_delay) begin
                        cnt = 0;
                        txn_q.push_back('{mem_we, mem_addr, mem_wline});
                        if (mem_we) mem_model[mem_addr] = mem_wline;
                        else        mem_rline = mem_line(mem_addr);
                        mem_ack = 1'b1;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] a,
                             input logic [255:0] line, input bit chk_line);
        mem_txn_t t;
        check({tag, "_present"}, 256'(txn_q.size() > 0), 256'd1);
        if (txn_q.size() > 0) begin
            t = txn_q.pop_front();
            check({tag, "_we"}, 256'(t.we), 256'(we));
            check({tag, "_addr"}, 256'(t.addr), 256'(a));
            if (chk_line) check({tag, "_line"}, t.line, line);
        end
    endtask

    // Issue one request, wait (bounded) for cpu_ready and compare read data
    // against the scoreboard. lat = cycles after the accepting edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp,
                          output int lat, output bit saw_mem);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        exp_q.push_back(exp);
        lat = 0;
        saw_mem = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (mem_req) saw_mem = 1'b1;
            if (cpu_ready) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            check("ready_seen", 256'(cpu_ready), 256'd1);
            exp_q.delete();
        end else begin
            check("rdata", 256'(cpu_rdata), 256'(exp_q.pop_front()));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        bit           saw;
        bit           seen;
        logic [255:0] line40;
        logic [255:0] exp_wb;

        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_be = '0; mem_ack = 1'b0; mem_rline = '0;

        line40 = dflt_line(32'h40);
        line40[95:64] = 32'hDEAD_BEEF;
        mem_model[32'h40] = line40;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 256'(cpu_ready), 256'd0);
        check("rst_stall", 256'(cpu_stall), 256'd0);
        check("rst_mem_req", 256'(mem_req), 256'd0);
        check("rst_arr_en", 256'(arr_enable), 256'd0);
        check("rst_rdata", 256'(cpu_rdata), 256'd0);
        check("rst_counters", 256'({hit_count, miss_count, wb_count}), 256'd0);
        rst = 1'b1;

        // clean load miss, refill acked after 3 cycles
        do_req(1'b0, 32'h48, 32'h0, 4'h0, 32'hDEAD_BEEF, lat, saw);
        check("miss_latency", 256'(lat), 256'd7);
        check_txn("refill40", 1'b0, 32'h40, '0, 1'b0);
        check("miss1_miss", 256'(miss_count), 256'd1);
        check("miss1_hit", 256'(hit_count), 256'd0);

        // load hit
        do_req(1'b0, 32'h48, 32'h0, 4'h0, 32'hDEAD_BEEF, lat, saw);
        check("hit_latency", 256'(lat), 256'd2);
        check("hit_no_mem", 256'(saw), 256'd0);
        check("hit1_hit", 256'(hit_count), 256'd1);

        // partial store hit, then reload
        do_req(1'b1, 32'h48, 32'h1122_3344, 4'b0101, 32'h0, lat, saw);
        check("store_latency", 256'(lat), 256'd3);
        do_req(1'b0, 32'h48, 32'h0, 4'h0, 32'hDE22_BE44, lat, saw);
        check("reload_latency", 256'(lat), 256'd2);
        check("hit3_hit", 256'(hit_count), 256'd3);

        // conflict miss on the dirty line: write-back then refill
        exp_wb = line40;
        exp_wb[95:64] = 32'hDE22_BE44;
        do_req(1'b0, 32'h848, 32'h0, 4'h0, 32'h0000_0848, lat, saw);
        check("wb_latency", 256'(lat), 256'd11);
        check_txn("wb40", 1'b1, 32'h40, exp_wb, 1'b1);
        check_txn("refill840", 1'b0, 32'h840, '0, 1'b0);
        check("wb_count", 256'(wb_count), 256'd1);
        check("miss2_miss", 256'(miss_count), 256'd2);

        // reset in the middle of a refill
        resp_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
        check("mid_refill_req", 256'(mem_req), 256'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_mem_req", 256'(mem_req), 256'd0);
        check("mid_rst_stall", 256'(cpu_stall), 256'd0);
        check("mid_rst_arr_en", 256'(arr_enable), 256'd0);
        check("mid_rst_counters", 256'({hit_count, miss_count, wb_count}), 256'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | cpu_ready | mem_req | cpu_stall;
        end
        check("late_ack_ignored", 256'(seen), 256'd0);
        resp_en = 1'b1;

        // miss counter wrap
        force dut.miss_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.miss_count;
        do_req(1'b0, 32'h2000, 32'h0, 4'h0, 32'h0000_2000, lat, saw);
        check("miss_wrap", 256'(miss_count), 256'd0);
        check("wrap_hit", 256'(hit_count), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
